// File: rtl/sar_ctrl_param.sv
// Parametrised SAR ADC sequencer: sample, per-bit comparator precharge/evaluate, registered result strobe.
// Optional back-to-back conversions are enabled by defining SAR_CONT_EN, which adds the cont input.
module sar_ctrl_param #(
  parameter int NBITS         = 6,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SAR_CONT_EN
  input  logic             cont,
`endif
  input  logic             comp_out,
  output logic             sample,
  output logic             comp_en,
  output logic             comp_rst,
  output logic [NBITS-1:0] d,
  output logic [NBITS-1:0] db,
  output logic [NBITS-1:0] dout,
  output logic             valid,
  output logic             busy
);

  localparam int IW = $clog2(NBITS);
  localparam int CW = 4;

  // IDLE wait start | SAMPLE track input | RSTPH precharge, trial bit set | EVAL decide bit | DONE strobe
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_RSTPH,
    S_EVAL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    idx_m1;
  logic [NBITS-1:0] trial_q, trial_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [NBITS-1:0] db_q;
  logic             sample_q, comp_en_q, comp_rst_q, valid_q, busy_q;

  assign idx_m1 = idx_q - IW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    trial_d = trial_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        trial_d = '0;
        if (start) begin
          state_d = S_SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
          idx_d   = IW'(NBITS - 1);
        end
      end
      S_SAMPLE: begin
        trial_d = '0;
        if (cnt_q == '0) begin
          state_d        = S_RSTPH;
          trial_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RSTPH: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (!comp_out) trial_d[idx_q] = 1'b0;
        if (idx_q == '0) begin
          state_d = S_DONE;
          res_d   = trial_d;
        end else begin
          state_d         = S_RSTPH;
          idx_d           = idx_m1;
          trial_d[idx_m1] = 1'b1;
        end
      end
      S_DONE: begin
        trial_d = '0;
        state_d = S_IDLE;
`ifdef SAR_CONT_EN
        if (cont) begin
          state_d = S_SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
          idx_d   = IW'(NBITS - 1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        trial_d = '0;
      end
    endcase
  end

  // Output flops decode the next state so every output is registered and aligned with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      trial_q    <= '0;
      res_q      <= '0;
      db_q       <= '1;
      sample_q   <= 1'b0;
      comp_en_q  <= 1'b0;
      comp_rst_q <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      trial_q    <= trial_d;
      res_q      <= res_d;
      db_q       <= ~trial_d;
      sample_q   <= (state_d == S_SAMPLE);
      comp_en_q  <= (state_d == S_EVAL);
      comp_rst_q <= (state_d != S_EVAL);
      valid_q    <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign sample   = sample_q;
  assign comp_en  = comp_en_q;
  assign comp_rst = comp_rst_q;
  assign d        = trial_q;
  assign db       = db_q;
  assign dout     = res_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Self-checking bench for sar_ctrl_param: ideal comparator, conversion-phase model, per-cycle compare.
module tb_sar_ctrl_param;
  localparam int N    = 6;
  localparam int S    = 2;
  localparam int MASK = (1 << N) - 1;
  localparam int LAST = S + 2 * N + 1;

  logic         clk = 1'b0;
  logic         rst, start, cont, comp_out;
  logic         sample, comp_en, comp_rst, valid, busy;
  logic [N-1:0] d, db, dout;
  int           vin;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int ph       = 0;
  int vin_m    = 0;
  int dout_m   = 0;
  int samp_cnt = 0;
  bit valid_prev = 1'b0;
  int trial_log[$];

  always #5 clk = ~clk;

  assign comp_out = (vin >= int'(d));

  sar_ctrl_param #(.NBITS(N), .SAMPLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef SAR_CONT_EN
    .cont     (cont),
`endif
    .comp_out (comp_out),
    .sample   (sample),
    .comp_en  (comp_en),
    .comp_rst (comp_rst),
    .d        (d),
    .db       (db),
    .dout     (dout),
    .valid    (valid),
    .busy     (busy)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: ph counts cycles since the accepting edge; 0 = idle, LAST = result cycle.
  always @(posedge clk) begin
    bit cont_eff;
`ifdef SAR_CONT_EN
    cont_eff = cont;
`else
    cont_eff = 1'b0;
`endif
    if (rst) begin
      ph = 0;
      dout_m = 0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1;
        vin_m = vin;
      end
    end else if (ph == LAST) begin
      if (cont_eff) begin
        ph = 1;
        vin_m = vin;
      end else begin
        ph = 0;
      end
    end else begin
      ph++;
      if (ph == LAST) dout_m = vin_m;
    end
  end

  always @(negedge clk) begin
    int rel, bi, ed;
    bit es, een, erst, ev, eb;
    es = 0; een = 0; erst = 1; ev = 0; eb = (ph != 0); ed = 0;
    if (ph >= 1 && ph <= S) begin
      es = 1;
    end else if (ph > S && ph < LAST) begin
      rel = ph - S - 1;
      bi  = N - 1 - rel / 2;
      ed  = ((vin_m >> (bi + 1)) << (bi + 1)) | (1 << bi);
      if (rel % 2 == 1) begin
        een = 1;
        erst = 0;
      end
    end else if (ph == LAST) begin
      ev = 1;
      ed = vin_m;
    end
    chk("sample", sample, es);
    chk("comp_en", comp_en, een);
    chk("comp_rst", comp_rst, erst);
    chk("valid", valid, ev);
    chk("busy", busy, eb);
    chk("d", d, ed);
    chk("db", db, (~ed) & MASK);
    chk("dout", dout, dout_m);
    chk("en_and_rst", comp_en & comp_rst, 0);
    chk("sample_and_en", sample & comp_en, 0);
    chk("valid_run", valid & valid_prev, 0);
    if (!busy) samp_cnt = 0;
    if (sample) samp_cnt++;
    if (valid) begin
      chk("sample_len", samp_cnt, S);
      samp_cnt = 0;
      n_valid++;
    end
    if (comp_en) trial_log.push_back(int'(d));
    valid_prev = valid;
  end

  task automatic run_conv(input int v, input bit spam, output int lat);
    vin = v;
    start = 1'b1;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (valid) break;
    end
    start = 1'b0;
    chk("valid_seen", valid, 1);
  endtask

  initial begin
    int lat, nv0, ne, cyc;
    int exp_tr[6];
    exp_tr = '{32, 48, 40, 44, 46, 45};
    rst = 1'b1; start = 1'b0; cont = 1'b0; vin = 0;
    repeat (3) @(negedge clk);
    chk("rst_db", db, 63);
    chk("rst_comp_rst", comp_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    @(negedge clk);

    trial_log.delete();
    run_conv(45, 1'b0, lat);
    chk("lat_45", lat, 15);
    chk("dout_45", dout, 45);
    chk("trial_count", trial_log.size(), 6);
    for (int k = 0; k < 6 && k < trial_log.size(); k++) chk("trial_seq", trial_log[k], exp_tr[k]);
    repeat (2) @(negedge clk);

    nv0 = n_valid;
    run_conv(0, 1'b0, lat);
    chk("dout_0", dout, 0);
    repeat (4) @(negedge clk);
    chk("valids_0", n_valid - nv0, 1);
    nv0 = n_valid;
    run_conv(63, 1'b0, lat);
    chk("dout_63", dout, 63);
    repeat (4) @(negedge clk);
    chk("valids_63", n_valid - nv0, 1);

    nv0 = n_valid;
    vin = 20;
    start = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == 3 || cyc == 10);
    end
    start = 1'b0;
    chk("busy_rej_valids", n_valid - nv0, 1);
    chk("busy_rej_dout", dout, 20);

    vin = 33;
    start = 1'b1;
    ne = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (comp_en) ne++;
      if (ne == 3) break;
    end
    chk("third_eval_seen", ne, 3);
    nv0 = n_valid;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_db", db, 63);
    chk("abort_comp_rst", comp_rst, 1);
    chk("abort_dout", dout, 0);
    chk("abort_valid", valid, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_valid", n_valid - nv0, 0);
    run_conv(17, 1'b0, lat);
    chk("dout_17", dout, 17);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 100; r++) begin
      int v;
      v = (r == 0) ? 0 : (r == 1) ? 63 : int'($urandom_range(0, 63));
      run_conv(v, 1'b1, lat);
      chk("rand_lat", lat, 15);
      chk("rand_dout", dout, v);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

`ifdef SAR_CONT_EN
    repeat (3) @(negedge clk);
    nv0 = n_valid;
    cont = 1'b1;
    run_conv(10, 1'b0, lat);
    chk("cont_lat1", lat, 15);
    chk("cont_dout1", dout, 10);
    vin = 50;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) cont = 1'b0;
      chk("cont_busy", busy, 1);
      if (valid) break;
    end
    chk("cont_lat2", lat, 15);
    chk("cont_dout2", dout, 50);
    @(negedge clk);
    chk("cont_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("cont_valids", n_valid - nv0, 2);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
